mips_branch_predictor: RTL and testbench

Dynamic branch predictor for the fetch stage of the 5-stage MIPS32 pipelined core. It provides a same-cycle taken/not-taken prediction and target for the current fetch PC, using a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It is trained by branch resolution in EX, where it also raises the flush/redirect request on a misprediction. It sits between the PC register and instruction memory on the fetch side, and consumes resolution results from the EX stage.

---
 rtl/mips_branch_predictor_if.sv | 32 +++
 rtl/mips_branch_predictor.sv | 103 ++++++++++
 tb/tb_mips_branch_predictor.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_branch_predictor_if.sv
// Fetch/EX bundle between the MIPS32 core and its branch predictor.
//   master : core side; drives the fetch PC and EX resolution, receives
//            prediction and redirect.
//   slave  : predictor side.
interface mips_branch_predictor_if #(
  parameter int unsigned PC_W = 32
);
  logic            if_pc_valid_unused;
  logic [PC_W-1:0] if_pc;
  logic            if_pred_taken;
  logic [PC_W-1:0] if_pred_target;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken,
           ex_pred_target,
    input  if_pred_taken, if_pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken,
           ex_pred_target,
    output if_pred_taken, if_pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/mips_branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB with 2-bit
// saturating counters, same-cycle lookup on if_pc, training and
// misprediction detection from EX.
//   clk, rst_n        : core clock, async active-low reset
//   bp (slave)        : if_pc -> if_pred_taken/if_pred_target;
//                       ex_* resolution -> mispredict/redirect_pc
//   perf_branches,
//   perf_mispredicts  : resolution/mispredict counters, present only when
//                       BP_PERF_CNT_EN is defined
module mips_branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned PC_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mips_branch_predictor_if.slave    bp
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]               perf_branches,
  output logic [31:0]               perf_mispredicts
`endif
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = PC_W - INDEX_BITS - 2;
  localparam int unsigned TGT_W   = PC_W - 2;

  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TGT_W-1:0] target_q [ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]      rd_tag, wr_tag;
  logic                  rd_hit, wr_hit;

  assign rd_idx = bp.if_pc[INDEX_BITS+1:2];
  assign rd_tag = bp.if_pc[PC_W-1:INDEX_BITS+2];
  assign wr_idx = bp.ex_pc[INDEX_BITS+1:2];
  assign wr_tag = bp.ex_pc[PC_W-1:INDEX_BITS+2];

  // Low PC bits never select an entry; instructions are word aligned.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, bp.if_pc[1:0], bp.ex_pc[1:0]};

  // Lookup: purely combinational, no bypass from a same-cycle update.
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign bp.if_pred_taken  = rd_hit && ctr_q[rd_idx][1];
  assign bp.if_pred_target = bp.if_pred_taken ? {target_q[rd_idx], 2'b00}
                                              : bp.if_pc + PC_W'(4);

  // Misprediction: wrong direction, or taken to a different target.
  assign bp.mispredict  = bp.ex_valid &&
                          ((bp.ex_taken != bp.ex_pred_taken) ||
                           (bp.ex_taken && (bp.ex_pred_target != bp.ex_target)));
  assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + PC_W'(4);

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Valid bits and counters: reset, trained on hit, allocated on taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (bp.ex_valid) begin
      if (wr_hit) begin
        if (bp.ex_taken) begin
          if (ctr_q[wr_idx] != 2'b11) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
        end else begin
          if (ctr_q[wr_idx] != 2'b00) ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
        end
      end else if (bp.ex_taken) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target payload: any taken resolution writes it (same tag on a hit,
  // replacement on a miss). Contents are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    if (bp.ex_valid && bp.ex_taken) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= bp.ex_target[PC_W-1:2];
    end
  end

`ifdef BP_PERF_CNT_EN
  // Free-running resolution and mispredict counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= 32'd0;
      perf_mispredicts <= 32'd0;
    end else begin
      if (bp.ex_valid)   perf_branches    <= perf_branches + 32'd1;
      if (bp.mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Directed self-checking bench for mips_branch_predictor.
module tb_mips_branch_predictor;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  always #5 clk = ~clk;

  mips_branch_predictor_if #(.PC_W(32)) bp ();

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  mips_branch_predictor #(.INDEX_BITS(6), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp.slave)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Present a fetch PC and check the same-cycle prediction.
  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_tgt);
    @(negedge clk);
    bp.if_pc = pc;
    #2;
    check({tag, "_taken"}, 32'(bp.if_pred_taken), 32'(exp_taken));
    check({tag, "_target"}, bp.if_pred_target, exp_tgt);
  endtask

  // Present one EX resolution for one cycle, check mispredict/redirect.
  task automatic resolve(input string tag, input logic [31:0] pc,
                         input logic taken, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt,
                         input logic exp_mis, input logic [31:0] exp_redir);
    @(negedge clk);
    bp.ex_valid       = 1'b1;
    bp.ex_pc          = pc;
    bp.ex_taken       = taken;
    bp.ex_target      = tgt;
    bp.ex_pred_taken  = ptaken;
    bp.ex_pred_target = ptgt;
    #2;
    check({tag, "_mis"}, 32'(bp.mispredict), 32'(exp_mis));
    check({tag, "_redir"}, bp.redirect_pc, exp_redir);
    exp_br++;
    if (exp_mis) exp_mp++;
    @(posedge clk);
    #1 bp.ex_valid = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bp.if_pc          = 32'h0040_0000;
    bp.ex_valid       = 1'b0;
    bp.ex_pc          = 32'h0;
    bp.ex_taken       = 1'b0;
    bp.ex_target      = 32'h0;
    bp.ex_pred_taken  = 1'b0;
    bp.ex_pred_target = 32'h0;
    #12;
    check("rst_taken", 32'(bp.if_pred_taken), 32'd0);
    check("rst_target", bp.if_pred_target, 32'h0040_0004);
    @(negedge clk) rst_n = 1'b1;

    lookup("post_rst", 32'h0040_0000, 1'b0, 32'h0040_0004);

    // Allocation on a taken miss.
    resolve("alloc", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014,
            1'b1, 32'h0040_0040);
    lookup("alloc_lk", 32'h0040_0010, 1'b1, 32'h0040_0040);

    // Saturate up, then walk down.
    for (int i = 0; i < 3; i++)
      resolve("sat_t", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040,
              1'b0, 32'h0040_0040);
    lookup("sat_lk", 32'h0040_0010, 1'b1, 32'h0040_0040);
    resolve("nt1", 32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040,
            1'b1, 32'h0040_0014);
    lookup("nt1_lk", 32'h0040_0010, 1'b1, 32'h0040_0040);
    resolve("nt2", 32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040,
            1'b1, 32'h0040_0014);
    lookup("nt2_lk", 32'h0040_0010, 1'b0, 32'h0040_0014);
    resolve("nt3", 32'h0040_0010, 1'b0, 32'h0040_0040, 1'b0, 32'h0040_0014,
            1'b0, 32'h0040_0014);
    lookup("nt3_lk", 32'h0040_0010, 1'b0, 32'h0040_0014);
    // ctr 00 -> 01: still not taken.
    resolve("t_from0", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014,
            1'b1, 32'h0040_0040);
    lookup("t_from0_lk", 32'h0040_0010, 1'b0, 32'h0040_0014);
    // ctr 01 -> 10, then a taken with wrong predicted target retrains target.
    resolve("t_01", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014,
            1'b1, 32'h0040_0040);
    resolve("bad_tgt", 32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0040,
            1'b1, 32'h0040_0080);
    lookup("bad_tgt_lk", 32'h0040_0010, 1'b1, 32'h0040_0080);

    // Aliasing: same index, different tag replaces the entry.
    resolve("alias", 32'h0040_0110, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0114,
            1'b1, 32'h0040_0200);
    lookup("alias_old", 32'h0040_0010, 1'b0, 32'h0040_0014);
    lookup("alias_new", 32'h0040_0110, 1'b1, 32'h0040_0200);

    // Not-taken miss: no allocation.
    resolve("nt_miss", 32'h0040_0030, 1'b0, 32'h0040_0500, 1'b0, 32'h0040_0034,
            1'b0, 32'h0040_0034);
    lookup("nt_miss_lk", 32'h0040_0030, 1'b0, 32'h0040_0034);

    // Same-cycle lookup and allocation: no bypass.
    @(negedge clk);
    bp.if_pc          = 32'h0040_0020;
    bp.ex_valid       = 1'b1;
    bp.ex_pc          = 32'h0040_0020;
    bp.ex_taken       = 1'b1;
    bp.ex_target      = 32'h0040_0300;
    bp.ex_pred_taken  = 1'b0;
    bp.ex_pred_target = 32'h0040_0024;
    #2;
    check("same_taken", 32'(bp.if_pred_taken), 32'd0);
    check("same_target", bp.if_pred_target, 32'h0040_0024);
    check("same_mis", 32'(bp.mispredict), 32'd1);
    exp_br++;
    exp_mp++;
    @(posedge clk);
    #1 bp.ex_valid = 1'b0;
    lookup("same_next", 32'h0040_0020, 1'b1, 32'h0040_0300);

    // ex_valid low: no mispredict and no training.
    @(negedge clk);
    bp.ex_pc         = 32'h0040_0040;
    bp.ex_taken      = 1'b1;
    bp.ex_target     = 32'h0040_0600;
    bp.ex_pred_taken = 1'b0;
    #2;
    check("idle_mis", 32'(bp.mispredict), 32'd0);
    lookup("idle_lk", 32'h0040_0040, 1'b0, 32'h0040_0044);

    // PC+4 wraps at the top of the address space.
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

`ifdef BP_PERF_CNT_EN
    #1;
    check("perf_br", perf_branches, 32'(exp_br));
    check("perf_mp", perf_mispredicts, 32'(exp_mp));
`endif

    // Asynchronous reset mid-run clears predictions immediately.
    @(negedge clk);
    bp.if_pc = 32'h0040_0020;
    #2 rst_n = 1'b0;
    #1;
    check("arst_taken", 32'(bp.if_pred_taken), 32'd0);
    check("arst_target", bp.if_pred_target, 32'h0040_0024);
`ifdef BP_PERF_CNT_EN
    check("arst_perf_br", perf_branches, 32'd0);
    check("arst_perf_mp", perf_mispredicts, 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    lookup("arst_alias", 32'h0040_0110, 1'b0, 32'h0040_0114);

    // First edge after reset release trains normally.
    resolve("realloc", 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014,
            1'b1, 32'h0040_0040);
    lookup("realloc_lk", 32'h0040_0010, 1'b1, 32'h0040_0040);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
